// File: rtl/motor602_deadtime_gate_pkg.sv
// Shared types for the motor602 dead-time gate: phase FSM encoding, request decode and defaults.
package motor602_deadtime_gate_pkg;

    localparam int unsigned DEAD_CYC_DEFAULT = 50;
    localparam int unsigned CNT_W_DEFAULT    = 8;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_DEAD = 2'd1,
        ST_HI   = 2'd2,
        ST_LO   = 2'd3
    } phase_state_e;

    typedef enum logic [1:0] {
        REQ_NONE    = 2'd0,
        REQ_HI      = 2'd1,
        REQ_LO      = 2'd2,
        REQ_ILLEGAL = 2'd3
    } req_e;

    function automatic req_e decode_req(input logic hi, input logic lo);
        case ({hi, lo})
            2'b10:   return REQ_HI;
            2'b01:   return REQ_LO;
            2'b11:   return REQ_ILLEGAL;
            default: return REQ_NONE;
        endcase
    endfunction

endpackage

// File: rtl/motor602_deadtime_phase.sv
// One bridge phase: OFF/DEAD/HI/LO FSM with dead-time counter and registered gate drives.
module motor602_deadtime_phase
    import motor602_deadtime_gate_pkg::*;
#(
    parameter int unsigned DEAD_CYC = DEAD_CYC_DEFAULT,
    parameter int unsigned CNT_W    = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic hi_req,
    input  logic lo_req,
    input  logic kill,
    output logic hi_on,
    output logic lo_n,
    output logic dead
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEAD_CYC - 1);

    phase_state_e     state;
    req_e             tgt;
    req_e             req;
    logic [CNT_W-1:0] cnt;
    logic             retarget;

    assign req = decode_req(hi_req, lo_req);

    // Every entry into DEAD (fresh turn-on or side swap) restarts the full dead time.
    assign retarget = (state == ST_OFF)
                   || (state == ST_DEAD && req != tgt)
                   || (state == ST_HI && req == REQ_LO)
                   || (state == ST_LO && req == REQ_HI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_OFF;
            tgt   <= REQ_NONE;
            cnt   <= '0;
            hi_on <= 1'b0;
            lo_n  <= 1'b1;
            dead  <= 1'b0;
        end else if (kill || req == REQ_NONE || req == REQ_ILLEGAL) begin
            state <= ST_OFF;
            tgt   <= REQ_NONE;
            cnt   <= '0;
            hi_on <= 1'b0;
            lo_n  <= 1'b1;
            dead  <= 1'b0;
        end else if (retarget) begin
            state <= ST_DEAD;
            tgt   <= req;
            cnt   <= RELOAD;
            hi_on <= 1'b0;
            lo_n  <= 1'b1;
            dead  <= 1'b1;
        end else if (state == ST_DEAD) begin
            if (cnt == '0) begin
                state <= (tgt == REQ_HI) ? ST_HI : ST_LO;
                hi_on <= (tgt == REQ_HI);
                lo_n  <= (tgt != REQ_LO);
                dead  <= 1'b0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/motor602_deadtime_gate.sv
// Dead-time gate top: three phase FSMs, sticky fault latch, force-stop and output polarity.
// Optional registered output monitor with chkErrO when MOTOR602_OUT_CHECK_EN is defined.
module motor602_deadtime_gate
    import motor602_deadtime_gate_pkg::*;
#(
    parameter int unsigned DEAD_CYC = DEAD_CYC_DEFAULT,
    parameter int unsigned CNT_W    = CNT_W_DEFAULT
) (
    input  logic       clk50mhzI,
    input  logic       rstI,
    input  logic [2:0] hiReqI,
    input  logic [2:0] loReqI,
    input  logic       forceStopI,
    input  logic       faultClrI,
    output logic       aHPo,
    output logic       bHPo,
    output logic       cHPo,
    output logic       aLNo,
    output logic       bLNo,
    output logic       cLNo,
    output logic [2:0] faultO,
`ifdef MOTOR602_OUT_CHECK_EN
    output logic       chkErrO,
`endif
    output logic [2:0] deadO
);

    logic [2:0] hp;
    logic [2:0] ln;
    logic [2:0] illegal;
    logic [2:0] fault_d;
    logic       kill;

    assign illegal = hiReqI & loReqI;

`ifdef MOTOR602_OUT_CHECK_EN
    logic chk_set;
    logic chk_d;

    assign chk_set = (|(hp & ~ln)) || ((hp == 3'b000) && ($countones(~ln) <= 1));
    assign chk_d   = (chkErrO & ~faultClrI) | chk_set;

    always_ff @(posedge clk50mhzI or posedge rstI) begin
        if (rstI) begin
            chkErrO <= 1'b0;
        end else begin
            chkErrO <= chk_d;
        end
    end

    assign fault_d = (faultO & ~{3{faultClrI}}) | illegal | {3{chk_d}};
`else
    // A new illegal request wins over a simultaneous clear.
    assign fault_d = (faultO & ~{3{faultClrI}}) | illegal;
`endif

    // Kill from the next fault state so every phase drops on the same edge the fault latches.
    assign kill = forceStopI | (|fault_d);

    always_ff @(posedge clk50mhzI or posedge rstI) begin
        if (rstI) begin
            faultO <= 3'b000;
        end else begin
            faultO <= fault_d;
        end
    end

    for (genvar p = 0; p < 3; p++) begin : g_phase
        motor602_deadtime_phase #(
            .DEAD_CYC(DEAD_CYC),
            .CNT_W   (CNT_W)
        ) u_phase (
            .clk   (clk50mhzI),
            .rst   (rstI),
            .hi_req(hiReqI[p]),
            .lo_req(loReqI[p]),
            .kill  (kill),
            .hi_on (hp[p]),
            .lo_n  (ln[p]),
            .dead  (deadO[p])
        );
    end

    assign aHPo = hp[0];
    assign bHPo = hp[1];
    assign cHPo = hp[2];
    assign aLNo = ln[0];
    assign bLNo = ln[1];
    assign cLNo = ln[2];

endmodule

// File: tb/tb_motor602_deadtime_gate.sv
// Directed bench for motor602_deadtime_gate with DEAD_CYC=50; checks sampled on the falling edge.
module tb_motor602_deadtime_gate;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] hi_req;
    logic [2:0] lo_req;
    logic       force_stop;
    logic       fault_clr;
    logic       a_hp, b_hp, c_hp, a_ln, b_ln, c_ln;
    logic [2:0] fault;
    logic [2:0] dead;
    logic [2:0] hp;
    logic [2:0] ln;

    int n_cmp = 0;
    int n_err = 0;

    always #10 clk = ~clk;

    assign hp = {c_hp, b_hp, a_hp};
    assign ln = {c_ln, b_ln, a_ln};

    motor602_deadtime_gate #(
        .DEAD_CYC(50),
        .CNT_W   (8)
    ) dut (
        .clk50mhzI (clk),
        .rstI      (rst),
        .hiReqI    (hi_req),
        .loReqI    (lo_req),
        .forceStopI(force_stop),
        .faultClrI (fault_clr),
        .aHPo      (a_hp),
        .bHPo      (b_hp),
        .cHPo      (c_hp),
        .aLNo      (a_ln),
        .bLNo      (b_ln),
        .cLNo      (c_ln),
        .faultO    (fault),
        .deadO     (dead)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_all(input string tag, input logic [2:0] e_hp, input logic [2:0] e_ln,
                             input logic [2:0] e_dead, input logic [2:0] e_fault);
        check({tag, "_hp"}, {5'd0, hp}, {5'd0, e_hp});
        check({tag, "_ln"}, {5'd0, ln}, {5'd0, e_ln});
        check({tag, "_dead"}, {5'd0, dead}, {5'd0, e_dead});
        check({tag, "_fault"}, {5'd0, fault}, {5'd0, e_fault});
        check({tag, "_shoot"}, {5'd0, hp & ~ln}, 8'd0);
    endtask

    initial begin
        rst        = 1'b1;
        hi_req     = 3'b000;
        lo_req     = 3'b000;
        force_stop = 1'b0;
        fault_clr  = 1'b0;
        step();
        check_all("in_reset", 3'b000, 3'b111, 3'b000, 3'b000);
        step();
        rst = 1'b0;

        // Idle after reset release.
        for (int k = 0; k < 100; k++) begin
            step();
            check_all("idle", 3'b000, 3'b111, 3'b000, 3'b000);
        end

        // Phase a turn-on: 50 DEAD cycles then HI.
        hi_req = 3'b001;
        for (int k = 1; k <= 50; k++) begin
            step();
            check_all("a_on_dead", 3'b000, 3'b111, 3'b001, 3'b000);
        end
        step();
        check_all("a_hi", 3'b001, 3'b111, 3'b000, 3'b000);

        // Swap a from HI to LO: off at once, both off for exactly 50 cycles.
        hi_req = 3'b000;
        lo_req = 3'b001;
        for (int k = 1; k <= 50; k++) begin
            step();
            check_all("a_swap_dead", 3'b000, 3'b111, 3'b001, 3'b000);
        end
        step();
        check_all("a_lo", 3'b000, 3'b110, 3'b000, 3'b000);

        // Turn-off latency of one cycle.
        lo_req = 3'b000;
        step();
        check_all("a_off", 3'b000, 3'b111, 3'b000, 3'b000);

        // Illegal on b while a also requests high: fault latches and everything stays off.
        hi_req = 3'b011;
        lo_req = 3'b010;
        step();
        check_all("b_illegal", 3'b000, 3'b111, 3'b000, 3'b010);
        hi_req = 3'b001;
        lo_req = 3'b000;
        for (int k = 0; k < 60; k++) begin
            step();
            check_all("fault_hold", 3'b000, 3'b111, 3'b000, 3'b010);
        end

        // Clear with requests removed.
        hi_req    = 3'b000;
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        check_all("fault_clr", 3'b000, 3'b111, 3'b000, 3'b000);

        // Clear and new illegal in the same cycle: fault wins.
        hi_req    = 3'b010;
        lo_req    = 3'b010;
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        check_all("clr_vs_illegal", 3'b000, 3'b111, 3'b000, 3'b010);
        hi_req    = 3'b000;
        lo_req    = 3'b000;
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        check_all("fault_clr2", 3'b000, 3'b111, 3'b000, 3'b000);

        // Normal operation resumes; withdrawing during DEAD returns to OFF.
        hi_req = 3'b001;
        step();
        check_all("resume_dead", 3'b000, 3'b111, 3'b001, 3'b000);
        hi_req = 3'b000;
        step();
        check_all("dead_abort", 3'b000, 3'b111, 3'b000, 3'b000);

        // Phase c to LO.
        lo_req = 3'b100;
        for (int k = 1; k <= 50; k++) begin
            step();
            check_all("c_on_dead", 3'b000, 3'b111, 3'b100, 3'b000);
        end
        step();
        check_all("c_lo", 3'b000, 3'b011, 3'b000, 3'b000);

        // Force stop for 20 cycles, then a full dead time again on release.
        force_stop = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            check_all("force_stop", 3'b000, 3'b111, 3'b000, 3'b000);
        end
        force_stop = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            step();
            check_all("c_release_dead", 3'b000, 3'b111, 3'b100, 3'b000);
        end
        step();
        check_all("c_lo_again", 3'b000, 3'b011, 3'b000, 3'b000);

        // Phase b into DEAD while c drops; assert reset with b's counter at 25.
        lo_req = 3'b000;
        hi_req = 3'b010;
        for (int k = 1; k <= 24; k++) begin
            step();
            check_all("b_dead", 3'b000, 3'b111, 3'b010, 3'b000);
        end
        step();
        rst = 1'b1;
        #1;
        check_all("async_rst", 3'b000, 3'b111, 3'b000, 3'b000);
        step();
        rst = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            step();
            check_all("b_fresh_dead", 3'b000, 3'b111, 3'b010, 3'b000);
        end
        step();
        check_all("b_hi", 3'b010, 3'b111, 3'b000, 3'b000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
